// File: rtl/riscv_defs.sv
// Shared definitions for the retire monitor: opcode constants for the
// OUTPUT_PORT selection, default halt-sequence words, halt FSM encoding and
// the result-select helper used by the top level.
package riscv_defs;

    localparam logic [6:0]  OPC_STORE      = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH     = 7'b1100011;

    // addi x1,x0,12 followed by jalr x0,0(x1) ends a test program.
    localparam logic [31:0] HALT_INST0_DEF = 32'h00c00093;
    localparam logic [31:0] HALT_INST1_DEF = 32'h00008067;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEEN0  = 2'd1,
        HALTED = 2'd2
    } halt_state_e;

    // Value reported for a retiring instruction: stores expose their data
    // address, branches their outcome, everything else its write-back data.
    function automatic logic [31:0] sel_result(
        input logic [31:0] inst,
        input logic [31:0] wd,
        input logic [31:0] addr,
        input logic        taken
    );
        logic [31:0] res;
        case (inst[6:0])
            OPC_STORE:  res = addr;
            OPC_BRANCH: res = {31'b0, taken};
            default:    res = wd;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/riscv_halt_detect.sv
// Halt-sequence detector. Watches accepted retires for HALT_INST0 followed
// directly by HALT_INST1 and then latches halted until reset.
// Ports:
//   CLK    in   clock, rising edge
//   RSTn   in   synchronous reset, active-low
//   en     in   a retire is accepted this cycle
//   inst   in   retiring instruction word
//   halted out  sticky halt flag (registered)
module riscv_halt_detect
    import riscv_defs::*;
#(
    parameter logic [31:0] HALT_INST0 = HALT_INST0_DEF,
    parameter logic [31:0] HALT_INST1 = HALT_INST1_DEF
) (
    input  logic        CLK,
    input  logic        RSTn,
    input  logic        en,
    input  logic [31:0] inst,
    output logic        halted
);

    halt_state_e state;

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            state  <= IDLE;
            halted <= 1'b0;
        end else if (en) begin
            case (state)
                IDLE: begin
                    if (inst == HALT_INST0)
                        state <= SEEN0;
                end
                SEEN0: begin
                    if (inst == HALT_INST1) begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end else if (inst != HALT_INST0) begin
                        // A repeated first word keeps us armed; anything else disarms.
                        state <= IDLE;
                    end
                end
                HALTED: begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= IDLE;
                    halted <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/riscv_retire_monitor.sv
// Observation-interface producer inside RISCV_TOP. Counts retired
// instructions, registers a per-instruction result on OUTPUT_PORT and raises
// a sticky HALT once the halt sequence has retired.
// Ports:
//   CLK         in   clock, rising edge
//   RSTn        in   synchronous reset, active-low
//   RET_VALID   in   one-cycle pulse per retiring instruction
//   RET_INST    in   retiring instruction word
//   RET_WD      in   write-back data
//   RET_ADDR    in   effective data address (stores)
//   RET_TAKEN   in   branch outcome (branches)
//   NUM_INST    out  retired-instruction count, wraps silently
//   OUTPUT_PORT out  result value of the last accepted retire
//   HALT        out  sticky halt flag
module riscv_retire_monitor
    import riscv_defs::*;
#(
    parameter int          CNT_WIDTH  = 32,
    parameter logic [31:0] HALT_INST0 = HALT_INST0_DEF,
    parameter logic [31:0] HALT_INST1 = HALT_INST1_DEF
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 RET_VALID,
    input  logic [31:0]          RET_INST,
    input  logic [31:0]          RET_WD,
    input  logic [31:0]          RET_ADDR,
    input  logic                 RET_TAKEN,
    output logic [CNT_WIDTH-1:0] NUM_INST,
    output logic [31:0]          OUTPUT_PORT,
    output logic                 HALT
);

    logic accept;
    logic halted;

    // Once halted, the whole observation interface freezes.
    assign accept = RET_VALID && !halted;
    assign HALT   = halted;

    riscv_halt_detect #(
        .HALT_INST0 (HALT_INST0),
        .HALT_INST1 (HALT_INST1)
    ) u_halt_detect (
        .CLK    (CLK),
        .RSTn   (RSTn),
        .en     (accept),
        .inst   (RET_INST),
        .halted (halted)
    );

    always_ff @(posedge CLK) begin
        if (!RSTn) begin
            NUM_INST    <= '0;
            OUTPUT_PORT <= '0;
        end else if (accept) begin
            NUM_INST    <= NUM_INST + CNT_WIDTH'(1);
            OUTPUT_PORT <= sel_result(RET_INST, RET_WD, RET_ADDR, RET_TAKEN);
        end
    end

endmodule
